// File: rtl/pulse_bcd_counter_pkg.sv
// Shared widths, constants and helpers for the pulse-driven BCD counter.
package pulse_bcd_counter_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam int         HEX_AN_W = 3;

    // Saturate a nibble into the legal BCD range 0..9.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/pulse_bcd_counter_digit.sv
// One BCD digit of the counter chain. step_in means "this digit moves this
// cycle" in the direction given by up/down; step_out ripples the carry or
// borrow to the next more significant digit.
import pulse_bcd_counter_pkg::*;

module bcd_digit (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    input  logic             step_in,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    output logic [BCD_W-1:0] value,
    output logic             step_out
);

    // Carry on 9 when counting up, borrow on 0 when counting down.
    always_comb begin
        step_out = 1'b0;
        if (step_in) begin
            if (up)
                step_out = (value == BCD_MAX);
            else if (down)
                step_out = (value == '0);
        end
    end

    // Digit register: reset, clamped load, or modulo-10 step.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= bcd_clamp(load_digit);
        end else if (step_in) begin
            if (up)
                value <= (value == BCD_MAX) ? '0 : value + 1'b1;
            else if (down)
                value <= (value == '0) ? BCD_MAX : value - 1'b1;
        end
    end

endmodule

// File: rtl/pulse_bcd_counter.sv
// Decimal event counter with load, wrap flags and a time-multiplexed
// digit scan for the hex display.
import pulse_bcd_counter_pkg::*;

module pulse_bcd_counter #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inc,
    input  logic                      dec,
    input  logic                      load,
    input  logic [BCD_W*DIGITS-1:0]   load_val,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic                      ovf,
    output logic                      unf,
    output logic [HEX_AN_W-1:0]       hex_an,
    output logic [BCD_W-1:0]          hex_data
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic              up;
    logic              down;
    logic [DIGITS:0]   chain;
    logic [DIV_W-1:0]  div;
    logic              div_tc;
    logic [HEX_AN_W-1:0] idx;
    logic [HEX_AN_W-1:0] idx_next;
    logic [BCD_W-1:0]  sel_digit;

    // Load wins over counting; simultaneous inc and dec cancel out.
    assign up       = inc & ~dec & ~load;
    assign down     = dec & ~inc & ~load;
    assign chain[0] = up | down;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .clk        (clk),
                .rst        (rst),
                .up         (up),
                .down       (down),
                .step_in    (chain[g]),
                .load       (load),
                .load_digit (load_val[g*BCD_W +: BCD_W]),
                .value      (bcd[g*BCD_W +: BCD_W]),
                .step_out   (chain[g+1])
            );
        end
    endgenerate

    // Wrap flags: a step rippling out of the top digit is a full wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= up & chain[DIGITS];
            unf <= down & chain[DIGITS];
        end
    end

    assign div_tc   = (div == DIV_W'(SCAN_DIV - 1));
    assign idx_next = !div_tc ? idx :
                      (idx == HEX_AN_W'(DIGITS - 1)) ? '0 : idx + 1'b1;

    // Pick the digit that the display will show after this edge.
    always_comb begin
        sel_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_next == HEX_AN_W'(i))
                sel_digit = bcd[i*BCD_W +: BCD_W];
        end
    end

    // Scan divider and registered display outputs, independent of counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= '0;
            idx      <= '0;
            hex_data <= '0;
        end else begin
            div      <= div_tc ? '0 : div + 1'b1;
            idx      <= idx_next;
            hex_data <= sel_digit;
        end
    end

    assign hex_an = idx;

endmodule

// File: tb/tb_pulse_bcd_counter.sv
// Randomized and directed bench for pulse_bcd_counter against an integer
// reference model of the decimal count and scan position.
module tb_pulse_bcd_counter;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int MODULUS  = 10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inc = 1'b0;
    logic        dec = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] bcd;
    logic        ovf;
    logic        unf;
    logic [2:0]  hex_an;
    logic [3:0]  hex_data;

    int n_checks = 0;
    int n_pass   = 0;
    int count    = 0;   // model count, plain integer 0..9999
    int ticks    = 0;   // non-reset edges since last reset

    always #5 clk = ~clk;

    pulse_bcd_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc),
        .dec      (dec),
        .load     (load),
        .load_val (load_val),
        .bcd      (bcd),
        .ovf      (ovf),
        .unf      (unf),
        .hex_an   (hex_an),
        .hex_data (hex_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int j = 0; j < DIGITS; j++) begin
            r[j*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int from_load(input logic [15:0] lv);
        int s, w, nib;
        s = 0;
        w = 1;
        for (int j = 0; j < DIGITS; j++) begin
            nib = int'(lv[j*4 +: 4]);
            if (nib > 9) nib = 9;
            s += nib * w;
            w *= 10;
        end
        return s;
    endfunction

    // Apply one cycle of inputs, advance the model, then check all outputs.
    task automatic cycle(input logic r, input logic i, input logic d,
                         input logic l, input logic [15:0] lv);
        int prev, exp_an;
        logic exp_ovf, exp_unf;
        logic [15:0] prev_bcd;
        logic [3:0] exp_data;
        rst = r; inc = i; dec = d; load = l; load_val = lv;
        @(posedge clk);
        prev    = count;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        if (r) begin
            count = 0;
            ticks = 0;
        end else begin
            ticks++;
            if (l) begin
                count = from_load(lv);
            end else if (i && !d) begin
                exp_ovf = (count == MODULUS - 1);
                count   = (count + 1) % MODULUS;
            end else if (d && !i) begin
                exp_unf = (count == 0);
                count   = (count + MODULUS - 1) % MODULUS;
            end
        end
        exp_an   = (ticks / SCAN_DIV) % DIGITS;
        prev_bcd = to_bcd(prev);
        exp_data = r ? 4'd0 : prev_bcd[exp_an*4 +: 4];
        #1;
        chk("bcd",      32'(bcd),      32'(to_bcd(count)));
        chk("ovf",      32'(ovf),      32'(exp_ovf));
        chk("unf",      32'(unf),      32'(exp_unf));
        chk("hex_an",   32'(hex_an),   32'(exp_an));
        chk("hex_data", 32'(hex_data), 32'(exp_data));
    endtask

    initial begin
        int p;
        logic [15:0] lv;
        // Reset held with inc pulsing.
        cycle(1, 1, 0, 0, 16'h0);
        cycle(1, 1, 0, 0, 16'h0);
        chk("rst_bcd_zero", 32'(bcd), 32'h0);

        // Single-digit and two-digit carries.
        cycle(0, 0, 0, 1, 16'h0009);
        cycle(0, 1, 0, 0, 16'h0);
        chk("carry_0010", 32'(bcd), 32'h0010);
        cycle(0, 0, 0, 1, 16'h0099);
        cycle(0, 1, 0, 0, 16'h0);
        chk("carry_0100", 32'(bcd), 32'h0100);

        // Full wrap up and back down.
        cycle(0, 0, 0, 1, 16'h9999);
        cycle(0, 1, 0, 0, 16'h0);
        chk("wrap_up_ovf", 32'(ovf), 32'h1);
        cycle(0, 0, 0, 0, 16'h0);
        cycle(0, 0, 1, 0, 16'h0);
        chk("wrap_dn_unf", 32'(unf), 32'h1);
        cycle(0, 0, 0, 0, 16'h0);

        // Clamped load, load beating inc, inc&dec cancel.
        cycle(0, 0, 0, 1, 16'h3A5F);
        chk("clamp_3959", 32'(bcd), 32'h3959);
        cycle(0, 1, 0, 1, 16'h0042);
        cycle(0, 1, 1, 0, 16'h0);
        chk("incdec_0042", 32'(bcd), 32'h0042);

        // Stable count so the scan pattern can be observed.
        cycle(0, 0, 0, 1, 16'h1234);
        for (int n = 0; n < 24; n++) cycle(0, 0, 0, 0, 16'h0);

        // Held inc burst, then reset in the middle of another burst.
        cycle(0, 0, 0, 1, 16'h0995);
        for (int n = 0; n < 12; n++) cycle(0, 1, 0, 0, 16'h0);
        chk("burst_1007", 32'(bcd), 32'h1007);
        for (int n = 0; n < 3; n++) cycle(0, 1, 0, 0, 16'h0);
        cycle(1, 1, 0, 0, 16'h0);
        chk("mid_rst", 32'(bcd), 32'h0);
        for (int n = 0; n < 3; n++) cycle(0, 1, 0, 0, 16'h0);

        // Random traffic, with loads near the wrap points now and then.
        for (int n = 0; n < 1500; n++) begin
            p  = int'($urandom_range(0, 99));
            lv = 16'($urandom_range(0, 65535));
            if (p < 2)        cycle(1, $urandom_range(0, 1) == 1, 0, 0, lv);
            else if (p < 6)   cycle(0, $urandom_range(0, 1) == 1, 0, 1, lv);
            else if (p < 8)   cycle(0, 0, 0, 1, ($urandom_range(0, 1) == 1) ? 16'h9998 : 16'h0001);
            else              cycle(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, lv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
